// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and register constants for the MIPS decode stage.
// Also holds the packed control bundle that the decoder hands to ID/EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read / 1-write register file with synchronous clear and write-through bypass.
// $0 is hard-wired to zero on both read ports.
module reg_file
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] r_regs [NUM_REGS];
  logic        w_wr_en;

  assign w_wr_en = we && (waddr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // A same-cycle write to the read index is forwarded so WB->ID needs no extra hazard cycle.
  assign rdata1 = (raddr1 == REG_ZERO)               ? 32'd0 :
                  (w_wr_en && (waddr == raddr1))      ? wdata : r_regs[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO)               ? 32'd0 :
                  (w_wr_en && (waddr == raddr2))      ? wdata : r_regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, control decode,
// sign extension and load-use hazard detection feeding the ID/EX register.
module id_stage
  import mips_pkg::*;
#(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc_in,
  input  logic [31:0] if_instr_in,
  input  logic        flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        pc_write,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] sign_ext,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic [1:0]  alu_op
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  logic [5:0]  w_opcode;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_out;
  logic        w_uses_rt;
  logic        w_stall;

  // Flush outranks stall so a squashed slot never stays frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_pc    <= if_pc_in;
      r_instr <= if_instr_in;
      r_valid <= 1'b1;
    end
  end

  assign w_opcode = r_instr[31:26];
  assign rs       = r_instr[25:21];
  assign rt       = r_instr[20:16];
  assign rd       = r_instr[15:11];
  assign sign_ext = {{16{r_instr[15]}}, r_instr[15:0]};
  assign pc_out   = r_pc;

  reg_file #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .rdata1 (read_data1),
    .rdata2 (read_data2)
  );

  always_comb begin
    w_ctrl    = '0;
    w_uses_rt = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_FUNCT;
        w_uses_rt        = 1'b1;
      end
      OP_LW: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALU_OP_SUB;
        w_uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      default: ;
    endcase
  end

  // rt only matters as a source for R-type, sw and beq; lw/addi overwrite it.
  assign w_stall = r_valid && ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((ex_rt == rs) || ((ex_rt == rt) && w_uses_rt));

  assign w_ctrl_out = (w_stall || !r_valid) ? '0 : w_ctrl;

  assign stall      = w_stall;
  assign pc_write   = ~w_stall;
  assign reg_dst    = w_ctrl_out.reg_dst;
  assign alu_src    = w_ctrl_out.alu_src;
  assign mem_to_reg = w_ctrl_out.mem_to_reg;
  assign reg_write  = w_ctrl_out.reg_write;
  assign mem_read   = w_ctrl_out.mem_read;
  assign mem_write  = w_ctrl_out.mem_write;
  assign branch     = w_ctrl_out.branch;
  assign alu_op     = w_ctrl_out.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Random + directed bench for id_stage, checked against a cycle-level reference
// model of the IF/ID slot, register contents and decode table.
module tb_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc_in, if_instr_in;
  logic        flush, wb_reg_write, ex_mem_read;
  logic [4:0]  wb_write_reg, ex_rt;
  logic [31:0] wb_write_data;
  logic        pc_write, stall;
  logic [31:0] pc_out, read_data1, read_data2, sign_ext;
  logic [4:0]  rs, rt, rd;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [1:0]  alu_op;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr;
  logic        m_valid;
  logic [31:0] m_rf [32];

  always #5 clk = ~clk;

  id_stage #(.NUM_REGS(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .if_pc_in(if_pc_in), .if_instr_in(if_instr_in),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .pc_write(pc_write), .stall(stall), .pc_out(pc_out),
    .read_data1(read_data1), .read_data2(read_data2), .sign_ext(sign_ext),
    .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .alu_op(alu_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Decode table: {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_1_0_0_0_10;
      6'h23:   return 9'b0_1_1_1_1_0_0_00;
      6'h2B:   return 9'b0_1_0_0_0_1_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_1_0_0_0_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic uses_rt_of(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
  endfunction

  function automatic logic model_stall();
    logic [4:0] s, t;
    s = m_instr[25:21];
    t = m_instr[20:16];
    return m_valid && ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == s) || ((ex_rt == t) && uses_rt_of(m_instr[31:26])));
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_reg_write && wb_write_reg == idx) return wb_write_data;
    return m_rf[idx];
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
  endfunction

  // Drive one cycle of inputs, let them settle, compare all outputs with the model.
  task automatic apply(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic wbe, input logic [4:0] wbr,
                       input logic [31:0] wbd, input logic exmr, input logic [4:0] exrt);
    logic        es;
    logic [8:0]  ec;
    reset = rst; if_pc_in = pc; if_instr_in = instr; flush = fl;
    wb_reg_write = wbe; wb_write_reg = wbr; wb_write_data = wbd;
    ex_mem_read = exmr; ex_rt = exrt;
    #4;
    es = model_stall();
    ec = (es || !m_valid) ? 9'b0 : ctl_of(m_instr[31:26]);
    chk("ctl", {23'd0, dut_ctl()}, {23'd0, ec});
    chk("stall", {31'd0, stall}, {31'd0, es});
    chk("pc_write", {31'd0, pc_write}, {31'd0, ~es});
    chk("pc_out", pc_out, m_pc);
    chk("rd1", read_data1, model_read(m_instr[25:21]));
    chk("rd2", read_data2, model_read(m_instr[20:16]));
    chk("sign_ext", sign_ext, 32'(signed'(m_instr[15:0])));
    chk("rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, m_instr[25:11]});
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge.
  task automatic tick();
    logic es;
    es = model_stall();
    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC; m_instr = 0; m_valid = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (wb_reg_write && wb_write_reg != 0) m_rf[wb_write_reg] = wb_write_data;
      if (flush) begin
        m_instr = 0; m_valid = 0;
      end else if (!es) begin
        m_pc = if_pc_in; m_instr = if_instr_in; m_valid = 1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h08;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
  endfunction

  initial begin
    logic [4:0] xr;
    // Initial reset without checks: model and DUT start from unknown state
    reset = 1; if_pc_in = 0; if_instr_in = 0; flush = 0; wb_reg_write = 0;
    wb_write_reg = 0; wb_write_data = 0; ex_mem_read = 0; ex_rt = 0;
    m_pc = 'x; m_instr = 'x; m_valid = 0;
    tick();

    // 1: reset held; then sweep every index with reset-cleared registers
    apply(1, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 32; i++) begin
      apply(0, 32'h4 * i, {6'h00, 5'(i), 5'(i), 16'h0}, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // 2: bypass on rs=5, then write to $0 is ignored
    apply(0, 32'h20, 32'h00A0_0000, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 32'h24, 32'h0000_0000, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    chk("bypass", read_data1, 32'hDEADBEEF);
    tick();
    apply(0, 32'h28, 32'h0, 0, 1, 0, 32'h1234, 0, 0);
    chk("zero_reg", read_data1, 32'd0);
    tick();

    // 3: lw $2,4($1)
    apply(0, 32'h44, 32'h8C22_0004, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 32'h48, 32'h0044_1820, 0, 0, 0, 0, 0, 0);
    chk("lw_ctl", {23'd0, dut_ctl()}, {23'd0, 9'b0_1_1_1_1_0_0_00});
    chk("lw_imm", sign_ext, 32'h4);
    chk("lw_pc", pc_out, 32'h44);
    tick();

    // 4: load-use stall on add $3,$2,$4, then release
    apply(0, 32'h4C, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 2);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_bubble", {23'd0, dut_ctl()}, 32'd0);
    tick();
    apply(0, 32'h4C, 32'h0044_1820, 0, 0, 0, 0, 0, 2);
    chk("lu_hold_pc", pc_out, 32'h48);
    chk("add_ctl", {23'd0, dut_ctl()}, {23'd0, 9'b1_0_0_1_0_0_0_10});
    tick();

    // 5: flush and hazard together
    apply(0, 32'h50, 32'h0, 1, 0, 0, 0, 1, 2);
    tick();
    apply(0, 32'h54, 32'h0, 0, 0, 0, 0, 1, 2);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_pcw", {31'd0, pc_write}, 32'd1);
    tick();

    // 6: addi $1,$0,-1 then undefined opcode 0x3F
    apply(0, 32'h58, 32'h2001_FFFF, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 32'h5C, 32'hFC00_0000, 0, 0, 0, 0, 0, 0);
    chk("addi_imm", sign_ext, 32'hFFFF_FFFF);
    chk("addi_ctl", {23'd0, dut_ctl()}, {23'd0, 9'b0_1_0_1_0_0_0_00});
    tick();
    apply(0, 32'h60, 32'h0, 0, 0, 0, 0, 0, 0);
    chk("bad_op_ctl", {23'd0, dut_ctl()}, 32'd0);
    tick();

    // Reset asserted during a stall
    apply(0, 32'h64, 32'h0044_1820, 0, 0, 0, 0, 0, 0);
    tick();
    apply(1, 32'h68, 32'h0, 0, 0, 0, 0, 1, 2);
    tick();
    apply(0, 32'h68, 32'h0, 0, 0, 0, 0, 1, 2);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    tick();

    // Randomized traffic with hazards steered toward the current ID operands
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: xr = m_instr[25:21];
        1: xr = m_instr[20:16];
        default: xr = 5'($urandom_range(0, 7));
      endcase
      apply(($urandom_range(0, 49) == 0), $urandom(), rand_instr(),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)), xr);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage MIPS pipeline. It sits directly upstream of the ID/EX pipeline register and drives every one of its inputs.
- Contains the IF/ID pipeline register, the 32x32 register file with write-through bypass, the main control decoder, sign extension and load-use hazard detection.
- Produces a bubble (all controls zero) on stall or invalid slot, and freezes PC and IF/ID during a load-use stall.

Parameters:
- NUM_REGS, 32, register-file depth (index width fixed at 5).
- RESET_PC, 32'h0000_0000, reset value of the held PC.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clears IF/ID valid, held PC/instr and all registers.
- if_pc_in  in  32  PC+4 from the IF stage.
- if_instr_in  in  32  fetched instruction.
- flush  in  1  taken branch resolved downstream; squashes the IF/ID slot.
- wb_reg_write  in  1  write-back enable.
- wb_write_reg  in  5  write-back destination.
- wb_write_data  in  32  write-back data.
- ex_mem_read  in  1  mem_read of the instruction currently in ID/EX.
- ex_rt  in  5  rt of the instruction currently in ID/EX.
- pc_write  out  1  PC enable to IF (0 during stall).
- stall  out  1  load-use hazard detected.
- pc_out  out  32  held PC+4.
- read_data1, read_data2  out  32 each  register operands for rs, rt.
- sign_ext  out  32  sign-extended imm[15:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  out  1 each  decoded controls.
- alu_op  out  2  00 add, 01 sub (beq), 10 R-type funct.

Behaviour:
- IF/ID register (pc, instr, valid) updates on posedge. Priority order:
  - reset: pc=RESET_PC, instr=0, valid=0.
  - else flush: instr=0, valid=0 (flush beats stall).
  - else stall: hold all fields.
  - else: load if_pc_in and if_instr_in, valid=1.
- Latency: an instruction sampled at edge N appears decoded on the outputs combinationally during cycle N. ID/EX captures it at edge N+1.
- Register file:
  - Write on posedge when wb_reg_write=1 and wb_write_reg!=0.
  - $0 always reads 0; all entries are 0 after reset.
  - Reads are combinational.
  - Bypass: if wb_reg_write=1 and wb_write_reg!=0 and wb_write_reg equals the read index, the port returns wb_write_data in the same cycle.
- Decoder, keyed on opcode instr[31:26]:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 0x2B sw: alu_src=1, mem_write=1, alu_op=00.
  - 0x04 beq: branch=1, alu_op=01.
  - 0x08 addi: alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0.
- Hazard: stall = valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==rs) | (ex_rt==rt & uses_rt)).
  - uses_rt=1 for R-type, sw and beq only.
- Bubble: when stall=1 or valid=0, all seven 1-bit controls and alu_op are forced to 0. Datapath outputs (pc_out, read_data*, sign_ext, rs/rt/rd) still reflect IF/ID.
- pc_write = ~stall.
- sign_ext = {{16{instr[15]}}, instr[15:0]}.
- Reset values of all outputs: controls 0, stall 0, pc_write 1, pc_out RESET_PC, read_data 0, sign_ext 0, rs/rt/rd 0.
- Reset asserted mid-stall clears the stall on the next cycle, because valid=0.

Decomposition:
- mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT;
  - REG_ZERO.
- Sub-module reg_file: 2 read ports, 1 write port, write-through bypass, synchronous reset. Decoder and hazard logic stay inline.

Test Plan:
1. Assert reset 2 cycles -> all controls 0, stall=0, pc_write=1, read_data1/2=0 for every index.
2. wb_reg_write=1, wb_write_reg=5, wb_write_data=0xDEADBEEF, ID instr has rs=5 -> read_data1=0xDEADBEEF in the same cycle. Then wb_write_reg=0 with data 0x1234 -> reading $0 returns 0.
3. Present if_instr_in=0x8C220004 (lw $2,4($1)), if_pc_in=0x44, then one edge ->
   - mem_read=1, alu_src=1, mem_to_reg=1, reg_write=1, alu_op=00;
   - sign_ext=0x4, rs=1, rt=2, pc_out=0x44.
4. ID holds 0x00441820 (add $3,$2,$4) with ex_mem_read=1, ex_rt=2 -> stall=1, pc_write=0, all controls 0, IF/ID unchanged after the edge. Then ex_mem_read=0 -> reg_dst=1, reg_write=1, alu_op=10.
5. Assert flush and hazard in the same cycle -> after the edge valid=0, controls 0, stall=0, pc_write=1.
6. Present if_instr_in=0x2001FFFF (addi $1,$0,-1) -> sign_ext=0xFFFFFFFF, alu_src=1, reg_write=1. Present opcode 0x3F -> all controls 0.
